// File: rtl/fp_mul_iter.sv
// Iterative floating-point multiplier. The significand product is built by a
// radix-4 Booth multiplier that retires two multiplier bits per cycle. A
// single rounding cycle follows, then the result is held until it is taken.
// Subnormal operands are treated as zero (flush-to-zero), and underflowing
// results are flushed to signed zero.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for operands; a special-case operand pair goes straight to OUT
// MUL   | one Booth step per cycle, ITER cycles in total
// RND   | normalise, round, form the exponent and flags
// OUT   | result and flags held until out_ready
module fp_mul_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int ITER  = (MAN_W + 3) / 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     fp_X,
  input  logic [EXP_W+MAN_W:0]     fp_Y,
  input  logic [2:0]               r_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     fp_Z,
  output logic                     ovrf,
  output logic                     udrf,
  output logic                     inexact,
  output logic                     invalid
);

  localparam int W  = EXP_W + MAN_W + 1;   // full word
  localparam int SW = MAN_W + 1;           // significand with hidden bit
  localparam int NB = 2 * ITER;            // multiplier register width
  localparam int AW = SW + 3;              // signed accumulator, headroom for +-2A
  localparam int PW = 2 * SW;              // product width
  localparam int EW = EXP_W + 2;           // signed exponent arithmetic width
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [EXP_W-1:0]    EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0]    EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [W-1:0]        QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EW-1:0] BIAS_S  = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] E_OVF   = EW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_RND, S_OUT} state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic signed [AW-1:0]   acc_q;
  logic [NB-1:0]          mb_q;
  logic                   prev_q;
  logic [SW-1:0]          ma_q;
  logic [EXP_W-1:0]       ex_q;
  logic [EXP_W-1:0]       ey_q;
  logic                   sign_q;
  logic [2:0]             rm_q;
  logic [W-1:0]           z_q;
  logic                   ovrf_q;
  logic                   udrf_q;
  logic                   inexact_q;
  logic                   invalid_q;

  // ---------------------------------------------------------------------
  // Operand classification at the input port
  // ---------------------------------------------------------------------
  logic [EXP_W-1:0] x_exp, y_exp;
  logic [MAN_W-1:0] x_man, y_man;
  logic             sign_in;
  logic             x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
  logic             spec_nan, spec_inf, spec_zero, is_special;
  logic [W-1:0]     spec_z;

  assign x_exp   = fp_X[W-2:MAN_W];
  assign y_exp   = fp_Y[W-2:MAN_W];
  assign x_man   = fp_X[MAN_W-1:0];
  assign y_man   = fp_Y[MAN_W-1:0];
  assign sign_in = fp_X[W-1] ^ fp_Y[W-1];

  assign x_zero = (x_exp == '0);
  assign y_zero = (y_exp == '0);
  assign x_inf  = (x_exp == EXP_ONES) && (x_man == '0);
  assign y_inf  = (y_exp == EXP_ONES) && (y_man == '0);
  assign x_nan  = (x_exp == EXP_ONES) && (x_man != '0);
  assign y_nan  = (y_exp == EXP_ONES) && (y_man != '0);

  assign spec_nan   = x_nan || y_nan || (x_zero && y_inf) || (x_inf && y_zero);
  assign spec_inf   = x_inf || y_inf;
  assign spec_zero  = x_zero || y_zero;
  assign is_special = spec_nan || spec_inf || spec_zero;

  // Special-case result in priority order: NaN, infinity, zero
  always_comb begin
    spec_z = {sign_in, {(W-1){1'b0}}};
    if (spec_nan) begin
      spec_z = QNAN;
    end else if (spec_inf) begin
      spec_z = {sign_in, EXP_ONES, {MAN_W{1'b0}}};
    end
  end

  // ---------------------------------------------------------------------
  // Radix-4 Booth step: {acc, mb} shifts right two bits per cycle
  // ---------------------------------------------------------------------
  logic [2:0]           bdig;
  logic signed [AW-1:0] ma_ext;
  logic signed [AW-1:0] pp;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] acc_d;
  logic [NB-1:0]        mb_d;

  assign bdig   = {mb_q[1], mb_q[0], prev_q};
  assign ma_ext = $signed({3'b000, ma_q});

  // Partial product selection and accumulate/shift
  always_comb begin
    pp = '0;
    unique case (bdig)
      3'b001, 3'b010: pp = ma_ext;
      3'b011:         pp = ma_ext <<< 1;
      3'b100:         pp = -(ma_ext <<< 1);
      3'b101, 3'b110: pp = -ma_ext;
      default:        pp = '0;
    endcase
    sum   = acc_q + pp;
    acc_d = sum >>> 2;
    mb_d  = {sum[1:0], mb_q[NB-1:2]};
  end

  // ---------------------------------------------------------------------
  // Normalise, round, exponent and flags (used in RND)
  // ---------------------------------------------------------------------
  logic [PW-1:0]         prod;
  logic [PW-1:0]         nv;
  logic                  norm_n, norm_r;
  logic [SW-1:0]         keep;
  logic                  g_bit, s_bit, inc;
  logic [SW:0]           rounded;
  logic [MAN_W-1:0]      frac_r;
  logic signed [EW-1:0]  e_sum;
  logic                  rnd_ovf, rnd_unf, to_inf;
  logic [W-1:0]          rnd_z;

  assign prod = PW'({acc_q, mb_q});

  // Rounding datapath; the final result word is chosen by the range checks
  always_comb begin
    norm_n = prod[PW-1];
    nv     = norm_n ? prod : (prod << 1);
    keep   = nv[PW-1:SW];
    g_bit  = nv[SW-1];
    s_bit  = |nv[SW-2:0];

    unique case (rm_q)
      3'b001:  inc = 1'b0;
      3'b010:  inc = sign_q && (g_bit || s_bit);
      3'b011:  inc = !sign_q && (g_bit || s_bit);
      3'b100:  inc = g_bit;
      default: inc = g_bit && (s_bit || keep[0]);
    endcase

    rounded = {1'b0, keep} + {{SW{1'b0}}, inc};
    norm_r  = rounded[SW];
    frac_r  = norm_r ? rounded[MAN_W:1] : rounded[MAN_W-1:0];

    e_sum = $signed({2'b00, ex_q}) + $signed({2'b00, ey_q}) - BIAS_S
          + $signed({{(EW-1){1'b0}}, norm_n}) + $signed({{(EW-1){1'b0}}, norm_r});

    rnd_ovf = !e_sum[EW-1] && (e_sum >= E_OVF);
    rnd_unf = e_sum[EW-1] || (e_sum == '0);

    unique case (rm_q)
      3'b001:  to_inf = 1'b0;
      3'b010:  to_inf = sign_q;
      3'b011:  to_inf = !sign_q;
      default: to_inf = 1'b1;
    endcase

    if (rnd_ovf) begin
      rnd_z = to_inf ? {sign_q, EXP_ONES, {MAN_W{1'b0}}}
                     : {sign_q, EXP_MAXF, {MAN_W{1'b1}}};
    end else if (rnd_unf) begin
      rnd_z = {sign_q, {(W-1){1'b0}}};
    end else begin
      rnd_z = {sign_q, e_sum[EXP_W-1:0], frac_r};
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM and all datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mb_q      <= '0;
      prev_q    <= 1'b0;
      ma_q      <= '0;
      ex_q      <= '0;
      ey_q      <= '0;
      sign_q    <= 1'b0;
      rm_q      <= '0;
      z_q       <= '0;
      ovrf_q    <= 1'b0;
      udrf_q    <= 1'b0;
      inexact_q <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (is_special) begin
              z_q       <= spec_z;
              ovrf_q    <= 1'b0;
              udrf_q    <= 1'b0;
              inexact_q <= 1'b0;
              invalid_q <= spec_nan;
              state_q   <= S_OUT;
            end else begin
              ma_q    <= {1'b1, x_man};
              mb_q    <= NB'({1'b1, y_man});
              acc_q   <= '0;
              prev_q  <= 1'b0;
              cnt_q   <= '0;
              ex_q    <= x_exp;
              ey_q    <= y_exp;
              sign_q  <= sign_in;
              rm_q    <= r_mode;
              state_q <= S_MUL;
            end
          end
        end
        S_MUL: begin
          acc_q  <= acc_d;
          mb_q   <= mb_d;
          prev_q <= mb_q[1];
          if (cnt_q == CW'(ITER - 1)) begin
            cnt_q   <= '0;
            state_q <= S_RND;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RND: begin
          z_q       <= rnd_z;
          ovrf_q    <= rnd_ovf;
          udrf_q    <= !rnd_ovf && rnd_unf;
          inexact_q <= rnd_ovf || rnd_unf || g_bit || s_bit;
          invalid_q <= 1'b0;
          state_q   <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign fp_Z      = z_q;
  assign ovrf      = ovrf_q;
  assign udrf      = udrf_q;
  assign inexact   = inexact_q;
  assign invalid   = invalid_q;

endmodule

// File: tb/tb_fp_mul_iter.sv
// Bench for fp_mul_iter at default widths (binary32). Results are compared
// with a reference model using plain integer arithmetic on the significands.
module tb_fp_mul_iter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp_X;
  logic [31:0] fp_Y;
  logic [2:0]  r_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] fp_Z;
  logic        ovrf;
  logic        udrf;
  logic        inexact;
  logic        invalid;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] last_z;

  fp_mul_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp_X      (fp_X),
    .fp_Y      (fp_Y),
    .r_mode    (r_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fp_Z      (fp_Z),
    .ovrf      (ovrf),
    .udrf      (udrf),
    .inexact   (inexact),
    .invalid   (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: returns {ovrf, udrf, inexact, invalid, z[31:0]}
  function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic [2:0] rm);
    int ex, ey, e, nn, nr, m;
    longint unsigned fx, fy, p, keep;
    bit g, s, inc, sg, nanx, nany, infx, infy, to_inf;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    fx = longint'(x[22:0]);
    fy = longint'(y[22:0]);
    sg = x[31] ^ y[31];
    m  = (rm > 3'd4) ? 0 : int'(rm);
    nanx = (ex == 255) && (fx != 0);
    nany = (ey == 255) && (fy != 0);
    infx = (ex == 255) && (fx == 0);
    infy = (ey == 255) && (fy == 0);
    if (nanx || nany || (ex == 0 && infy) || (infx && ey == 0))
      return {4'b0001, 32'h7fc00000};
    if (infx || infy)
      return {4'b0000, sg, 8'hff, 23'd0};
    if (ex == 0 || ey == 0)
      return {4'b0000, sg, 31'd0};
    p  = (64'h800000 + fx) * (64'h800000 + fy);
    nn = int'((p >> 47) & 1);
    if (nn == 0) p = p << 1;
    keep = p >> 24;
    g    = ((p >> 23) & 1) != 0;
    s    = (p & 64'h7fffff) != 0;
    case (m)
      1:       inc = 0;
      2:       inc = sg && (g || s);
      3:       inc = !sg && (g || s);
      4:       inc = g;
      default: inc = g && (s || ((keep & 1) != 0));
    endcase
    keep = keep + (inc ? 64'd1 : 64'd0);
    nr = 0;
    if (keep >= 64'h1000000) begin
      keep = keep >> 1;
      nr   = 1;
    end
    e = ex + ey - 127 + nn + nr;
    if (e >= 255) begin
      case (m)
        1:       to_inf = 0;
        2:       to_inf = sg;
        3:       to_inf = !sg;
        default: to_inf = 1;
      endcase
      return to_inf ? {4'b1010, sg, 8'hff, 23'd0} : {4'b1010, sg, 8'hfe, 23'h7fffff};
    end
    if (e <= 0)
      return {4'b0110, sg, 31'd0};
    return {2'b00, g || s, 1'b0, sg, 8'(e), 23'(keep)};
  endfunction

  // Present operands, wait for the result (bounded), leave it un-taken
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm,
                       output int lat);
    fp_X     = x;
    fp_Y     = y;
    r_mode   = rm;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    fp_X     = $urandom;
    fp_Y     = $urandom;
    r_mode   = 3'($urandom_range(0, 7));
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic [2:0] rm, input int exp_lat);
    int lat;
    logic [35:0] r;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    issue(x, y, rm, lat);
    r = ref_mul(x, y, rm);
    chk({tag, "_ov"}, 32'(out_valid), 32'd1);
    chk({tag, "_z"}, fp_Z, r[31:0]);
    chk({tag, "_fl"}, 32'({ovrf, udrf, inexact, invalid}), 32'(r[35:32]));
    if (exp_lat > 0) chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    last_z = fp_Z;
    take_result();
  endtask

  function automatic logic [31:0] rnd_operand();
    int k;
    logic [7:0] e;
    k = int'($urandom_range(0, 19));
    case (k)
      0: return {1'($urandom), 31'd0};
      1: return {1'($urandom), 8'hff, 23'd0};
      2: return {1'($urandom), 8'hff, 23'($urandom_range(1, 32'h7fffff))};
      3: return {1'($urandom), 8'h00, 23'($urandom_range(1, 32'h7fffff))};
      default: begin
        e = (k < 12) ? 8'($urandom_range(1, 254)) : 8'($urandom_range(100, 154));
        return {1'($urandom), e, 23'($urandom)};
      end
    endcase
  endfunction

  initial begin
    int lat;
    int seen;
    logic [35:0] r;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    fp_X      = '0;
    fp_Y      = '0;
    r_mode    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_z", fp_Z, 32'd0);
    chk("rst_fl", 32'({ovrf, udrf, inexact, invalid}), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("tp_9", 32'h40400000, 32'h40400000, 3'b001, 15);
    chk("tp_9c", last_z, 32'h41100000);
    do_op("tp_rne", 32'h3fffffff, 32'h3fffffff, 3'b000, 15);
    chk("tp_rnec", last_z, 32'h407ffffe);
    do_op("ovf_rne", 32'h7f000000, 32'h7f000000, 3'b000, 0);
    chk("ovf_rnec", last_z, 32'h7f800000);
    do_op("ovf_rtz", 32'h7f000000, 32'h7f000000, 3'b001, 0);
    chk("ovf_rtzc", last_z, 32'h7f7fffff);
    do_op("ovf_rdn", 32'hff000000, 32'h7f000000, 3'b010, 0);
    chk("ovf_rdnc", last_z, 32'hff800000);
    do_op("ovf_rup", 32'hff000000, 32'h7f000000, 3'b011, 0);
    chk("ovf_rupc", last_z, 32'hff7fffff);
    do_op("sub", 32'h802df854, 32'h40490fdb, 3'b000, 1);
    chk("subc", last_z, 32'h80000000);
    do_op("nan", 32'h00000000, 32'h7f800000, 3'b000, 1);
    chk("nanc", last_z, 32'h7fc00000);
    do_op("unf", 32'h00800000, 32'h3f000000, 3'b000, 0);
    chk("unfc", last_z, 32'h00000000);
    do_op("rmm", 32'h3fc00001, 32'h3fc00001, 3'b100, 0);
    do_op("rm7", 32'h3fc00001, 32'h3fc00003, 3'b111, 0);

    // Backpressure: result held, new operands ignored while busy
    issue(32'h40400000, 32'h40400000, 3'b000, lat);
    chk("bp_ov", 32'(out_valid), 32'd1);
    fp_X = 32'h3f800000;
    fp_Y = 32'h40000000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_z", fp_Z, 32'h41100000);
      chk("bp_fl", 32'({ovrf, udrf, inexact, invalid}), 32'd0);
      chk("bp_rdy", 32'(in_ready), 32'd0);
      chk("bp_ov2", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    take_result();
    chk("bp_rdy_after", 32'(in_ready), 32'd1);
    chk("bp_ov_after", 32'(out_valid), 32'd0);

    // Reset during MUL discards the operation
    fp_X = 32'h40400000;
    fp_Y = 32'h40a00000;
    r_mode = 3'b000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mrst_ov", 32'(out_valid), 32'd0);
    chk("mrst_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mrst_rdy2", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("mrst_noout", 32'(seen), 32'd0);
    do_op("post_rst", 32'h40400000, 32'h40a00000, 3'b000, 15);

    // Randomised operands and modes against the reference model
    for (int i = 0; i < 300; i++) begin
      logic [31:0] x, y;
      logic [2:0]  rm;
      x  = rnd_operand();
      y  = rnd_operand();
      rm = 3'($urandom_range(0, 7));
      do_op("rnd", x, y, rm, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
